chan_accum: RTL



---
 rtl/chan_accum_pkg.sv | 73 +++++++
 rtl/chan_accum_psum.sv | 28 ++
 rtl/chan_accum.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/chan_accum_pkg.sv
// chan_accum_pkg: shared constants, pass-state type and the FP32 add helper used by chan_accum.
// No ports. fp32_add is a combinational single-precision adder: round-to-nearest-even, denormal
// inputs and underflowing results are flushed to +0.0, and Inf/NaN operands pass through.
package chan_accum_pkg;

    localparam int unsigned FP32_W        = 32;
    localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
    localparam int unsigned FP32_SIGN_BIT = 31;

    typedef enum logic [1:0] {PASS_FIRST, PASS_MID, PASS_LAST} pass_state_e;

    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  ex, ey;
        logic [26:0] mx, my, my_sh;  // hidden bit + 23 fraction + guard/round/sticky
        logic [27:0] sum;
        logic        sticky;
        logic        round_up;
        logic [24:0] mant_r;
        int          d;
        int          exp_r;
        // x always carries the larger magnitude, so it sets the sign and the exponent
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = x[30:23];
        ey = y[30:23];
        if (ex == 8'hff) return x;
        if (ex == 8'h00) return FP32_ZERO;
        mx = {1'b1, x[22:0], 3'b000};
        my = (ey == 8'h00) ? 27'd0 : {1'b1, y[22:0], 3'b000};
        d  = int'(ex) - int'(ey);
        if (d > 26) begin
            my_sh  = 27'd0;
            sticky = |my;
        end else begin
            my_sh  = my >> d;
            sticky = |(my & ((27'd1 << d) - 27'd1));
        end
        my_sh[0] = my_sh[0] | sticky;
        exp_r    = int'(ex);
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, my_sh};
            if (sum[27]) begin
                sum   = {1'b0, sum[27:2], sum[1] | sum[0]};
                exp_r = exp_r + 1;
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, my_sh};
            if (sum == 28'd0) return FP32_ZERO;
            for (int i = 0; i < 27; i++) begin
                if (!sum[26]) begin
                    sum   = sum << 1;
                    exp_r = exp_r - 1;
                end
            end
        end
        if (exp_r <= 0) return FP32_ZERO;
        round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
        mant_r   = {1'b0, sum[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            mant_r = mant_r >> 1;
            exp_r  = exp_r + 1;
        end
        if (exp_r >= 255) return {x[31], 8'hff, 23'd0};
        return {x[31], exp_r[7:0], mant_r[22:0]};
    endfunction

endpackage

// File: rtl/chan_accum_psum.sv
// psum_buf: per-pixel partial-sum storage for chan_accum.
// Depth words of FP32; synchronous write, asynchronous read, contents not reset.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (combinational read port).
module psum_buf
    import chan_accum_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AddrW-1:0]  waddr,
    input  logic [FP32_W-1:0] wdata,
    input  logic [AddrW-1:0]  raddr,
    output logic [FP32_W-1:0] rdata
);

    logic [FP32_W-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/chan_accum.sv
// chan_accum: accumulates num_pass passes of per-pixel FP32 partial sums, adds the bias on the
// first pass, and emits the final result on the last pass, two cycles after its input.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_sof input stream; bias_in;
// out_valid/out_data/out_sof result stream; sof_err sticky misplaced-start flag.
// Optional build macro CHAN_ACCUM_RELU_EN: negative final results (incl. -0.0) become +0.0.
module chan_accum
    import chan_accum_pkg::*;
#(
    parameter int unsigned input_x  = 4,
    parameter int unsigned input_y  = 4,
    parameter int unsigned num_pass = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_sof,
    input  logic [31:0] bias_in,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        sof_err
);

    localparam int unsigned NPix  = input_x * input_y;
    localparam int unsigned PixW  = $clog2(NPix);
    localparam int unsigned PassW = (num_pass > 1) ? $clog2(num_pass) : 1;
    localparam logic [PixW-1:0]  PixLast  = PixW'(NPix - 1);
    localparam logic [PassW-1:0] PassLast = PassW'(num_pass - 1);

    logic [PixW-1:0]  pix_cnt_q, pix_cnt_d, pix_eff;
    logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
    logic             sof_err_q, sof_err_d, sof_fault;
    logic             s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic [31:0]      s1_data_q, s1_data_d;
    logic [PixW-1:0]  s1_addr_q, s1_addr_d;
    logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [31:0]      psum, sum, result;
    logic             buf_we, in_first, in_last;
    pass_state_e      pass_state;

    always_comb begin
        if (pass_cnt_q == '0) begin
            pass_state = PASS_FIRST;
        end else if (pass_cnt_q == PassLast) begin
            pass_state = PASS_LAST;
        end else begin
            pass_state = PASS_MID;
        end
    end

    assign in_first = (pass_state == PASS_FIRST);
    // With a single pass the first pass is also the last
    assign in_last  = (pass_state == PASS_LAST) || (num_pass == 1);

    always_comb begin
        // A start marker away from pixel 0 restarts the pass at pixel 0 without touching pass_cnt
        sof_fault  = in_valid && in_sof && (pix_cnt_q != '0);
        pix_eff    = sof_fault ? '0 : pix_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        pass_cnt_d = pass_cnt_q;
        sof_err_d  = sof_err_q | sof_fault;
        s1_valid_d = in_valid;
        s1_data_d  = s1_data_q;
        s1_addr_d  = s1_addr_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        if (in_valid) begin
            s1_data_d  = in_data;
            s1_addr_d  = pix_eff;
            s1_first_d = in_first;
            s1_last_d  = in_last;
            if (pix_eff == PixLast) begin
                pix_cnt_d  = '0;
                pass_cnt_d = (pass_cnt_q == PassLast) ? '0 : pass_cnt_q + 1'b1;
            end else begin
                pix_cnt_d = pix_eff + 1'b1;
            end
        end

        sum = fp32_add(s1_data_q, s1_first_q ? bias_in : psum);
`ifdef CHAN_ACCUM_RELU_EN
        result = sum[FP32_SIGN_BIT] ? FP32_ZERO : sum;
`else
        result = sum;
`endif

        out_valid_d = s1_valid_q && s1_last_q;
        out_sof_d   = out_valid_d && (s1_addr_q == '0);
        out_data_d  = out_valid_d ? result : out_data_q;
        // Intermediate passes write back the raw sum; no bypass needed since NPix >= 2
        buf_we      = s1_valid_q && !s1_last_q && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            sof_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_addr_q   <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            sof_err_q   <= sof_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_addr_q   <= s1_addr_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
        end
    end

    psum_buf #(
        .Depth (NPix),
        .AddrW (PixW)
    ) u_psum_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (s1_addr_q),
        .wdata (sum),
        .raddr (s1_addr_q),
        .rdata (psum)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign sof_err   = sof_err_q;

endmodule
